// File: rtl/bulb_sequencer.sv
// rtl/bulb_sequencer.sv - debounced switch-to-bulb sequencer with dead time and blink
//
// Purpose: lights one of N_SEL+1 bulbs from a main switch and N_SEL select
// switches. One active select switch picks its bulb; any other pattern picks
// the default bulb N_SEL. Raw switches are synchronised and debounced. A bulb
// change goes through DEAD_CYCLES all-off cycles (break-before-make). An
// optional blink mode gates the lit bulb on/off every BLINK_HALF cycles.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   main_sw    in   raw main switch (asynchronous)
//   sel_sw     in   raw select switches [N_SEL-1:0] (asynchronous)
//   blink_en   in   raw blink-mode switch (asynchronous)
//   bulb       out  registered bulb drive [N_SEL:0], at most one bit high
//   active_idx out  registered index of the selected bulb
//   busy       out  registered, high while in the DEAD state
module bulb_sequencer #(
   parameter int N_SEL       = 2,
   parameter int DB_CYCLES   = 4,
   parameter int DEAD_CYCLES = 2,
   parameter int BLINK_HALF  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       main_sw,
   input  logic [N_SEL-1:0]           sel_sw,
   input  logic                       blink_en,
   output logic [N_SEL:0]             bulb,
   output logic [$clog2(N_SEL+1)-1:0] active_idx,
   output logic                       busy
);

   localparam int IW  = $clog2(N_SEL + 1);
   localparam int NW  = N_SEL + 2;
   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int DW  = $clog2(DEAD_CYCLES + 1);
   localparam int PW  = $clog2(BLINK_HALF + 1);

   localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
   localparam logic [DW-1:0]  DEAD_LOAD = DW'(DEAD_CYCLES);
   localparam logic [DW-1:0]  DEAD_ONE  = DW'(1);
   localparam logic [PW-1:0]  PH_LAST   = PW'(BLINK_HALF - 1);
   localparam logic [IW-1:0]  DEF_IDX   = IW'(N_SEL);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_DEAD = 2'd2
   } state_t;

   // Input path: raw vector layout is {blink, main, sel[N_SEL-1:0]}
   logic [NW-1:0]  raw;
   logic [NW-1:0]  sync1_q, sync1_d;
   logic [NW-1:0]  sync2_q, sync2_d;
   logic [NW-1:0]  db_q, db_d;
   logic [DBW-1:0] db_cnt_q [NW];
   logic [DBW-1:0] db_cnt_d [NW];

   logic [N_SEL-1:0] sel_db;
   logic             main_db;
   logic             blink_db;

   // Target decode
   logic          tgt_valid;
   logic [IW-1:0] tgt_idx;

   // Sequencer state
   state_t         state_q, state_d;
   logic [IW-1:0]  cur_q, cur_d;
   logic [DW-1:0]  dead_cnt_q, dead_cnt_d;
   logic [PW-1:0]  phase_cnt_q, phase_cnt_d;
   logic           phase_on_q, phase_on_d;
   logic [N_SEL:0] bulb_q, bulb_d;
   logic [IW-1:0]  active_idx_q, active_idx_d;
   logic           busy_q, busy_d;

   assign raw = {blink_en, main_sw, sel_sw};

   // Synchroniser and per-bit debounce: a bit only follows its synchronised
   // value after DB_CYCLES consecutive disagreeing cycles.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      db_d    = db_q;
      for (int i = 0; i < NW; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               db_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign sel_db   = db_q[N_SEL-1:0];
   assign main_db  = db_q[N_SEL];
   assign blink_db = db_q[N_SEL+1];

   // Exactly one select bit set picks that bulb; anything else picks DEF_IDX.
   always_comb begin
      logic          seen_one;
      logic          seen_many;
      logic [IW-1:0] sel_idx;
      seen_one  = 1'b0;
      seen_many = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < N_SEL; i++) begin
         if (sel_db[i]) begin
            if (seen_one) begin
               seen_many = 1'b1;
            end
            seen_one = 1'b1;
            sel_idx  = IW'(i);
         end
      end
      tgt_valid = main_db;
      tgt_idx   = (seen_one && !seen_many) ? sel_idx : DEF_IDX;
   end

   // Next-state logic. The dead counter is loaded once on entry and is not
   // restarted by later target changes; the exit samples the newest target.
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      dead_cnt_d = dead_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (tgt_valid) begin
               state_d = S_ON;
               cur_d   = tgt_idx;
            end
         end
         S_ON: begin
            if (!tgt_valid) begin
               state_d = S_IDLE;
            end else if (tgt_idx != cur_q) begin
               state_d    = S_DEAD;
               dead_cnt_d = DEAD_LOAD;
            end
         end
         S_DEAD: begin
            if (!tgt_valid) begin
               state_d    = S_IDLE;
               dead_cnt_d = '0;
            end else if (dead_cnt_q == DEAD_ONE) begin
               state_d    = S_ON;
               cur_d      = tgt_idx;
               dead_cnt_d = '0;
            end else begin
               dead_cnt_d = dead_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are computed from the next state so they register alongside it.
   // The blink phase only advances while staying in ON with blink enabled;
   // every other path parks it at the start of an on phase, which gives the
   // fresh on phase on ON entry, on blink rising and the forced-on at blink fall.
   always_comb begin
      phase_cnt_d = '0;
      phase_on_d  = 1'b1;
      if (state_q == S_ON && state_d == S_ON && blink_db) begin
         if (phase_cnt_q == PH_LAST) begin
            phase_on_d = !phase_on_q;
         end else begin
            phase_cnt_d = phase_cnt_q + 1'b1;
            phase_on_d  = phase_on_q;
         end
      end

      bulb_d = '0;
      if (state_d == S_ON && phase_on_d) begin
         for (int i = 0; i <= N_SEL; i++) begin
            bulb_d[i] = (cur_d == IW'(i));
         end
      end

      active_idx_d = (state_d == S_ON) ? cur_d : active_idx_q;
      busy_d       = (state_d == S_DEAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         db_q         <= '0;
         for (int i = 0; i < NW; i++) begin
            db_cnt_q[i] <= '0;
         end
         state_q      <= S_IDLE;
         cur_q        <= '0;
         dead_cnt_q   <= '0;
         phase_cnt_q  <= '0;
         phase_on_q   <= 1'b0;
         bulb_q       <= '0;
         active_idx_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         db_q         <= db_d;
         for (int i = 0; i < NW; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
         state_q      <= state_d;
         cur_q        <= cur_d;
         dead_cnt_q   <= dead_cnt_d;
         phase_cnt_q  <= phase_cnt_d;
         phase_on_q   <= phase_on_d;
         bulb_q       <= bulb_d;
         active_idx_q <= active_idx_d;
         busy_q       <= busy_d;
      end
   end

   assign bulb       = bulb_q;
   assign active_idx = active_idx_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_bulb_sequencer.sv
// tb/tb_bulb_sequencer.sv - directed bench for bulb_sequencer at default parameters
module tb_bulb_sequencer;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       main_sw  = 1'b0;
   logic [1:0] sel_sw   = 2'b00;
   logic       blink_en = 1'b0;
   logic [2:0] bulb;
   logic [1:0] active_idx;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       m;
      logic [1:0] s;
      int         hold;
      logic [2:0] e_bulb;
      logic [1:0] e_idx;
      logic       e_busy;
   } vec_t;

   vec_t vt[8];

   always #5 clk = ~clk;

   bulb_sequencer #(
      .N_SEL(2),
      .DB_CYCLES(4),
      .DEAD_CYCLES(2),
      .BLINK_HALF(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .main_sw(main_sw),
      .sel_sw(sel_sw),
      .blink_en(blink_en),
      .bulb(bulb),
      .active_idx(active_idx),
      .busy(busy)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string name, input logic [2:0] eb, input logic [1:0] ei,
                          input logic ebusy);
      chk({name, ".bulb"}, int'(bulb), int'(eb));
      chk({name, ".idx"}, int'(active_idx), int'(ei));
      chk({name, ".busy"}, int'(busy), int'(ebusy));
   endtask

   initial begin
      vt[0] = '{1'b1, 2'b00, 14, 3'b100, 2'd2, 1'b0};
      vt[1] = '{1'b1, 2'b01, 14, 3'b001, 2'd0, 1'b0};
      vt[2] = '{1'b1, 2'b10, 14, 3'b010, 2'd1, 1'b0};
      vt[3] = '{1'b1, 2'b11, 14, 3'b100, 2'd2, 1'b0};
      vt[4] = '{1'b0, 2'b11, 14, 3'b000, 2'd2, 1'b0};
      vt[5] = '{1'b1, 2'b01, 14, 3'b001, 2'd0, 1'b0};
      vt[6] = '{1'b0, 2'b00, 14, 3'b000, 2'd0, 1'b0};
      vt[7] = '{1'b1, 2'b10, 14, 3'b010, 2'd1, 1'b0};

      // Reset state
      tick(3);
      chk_all("reset", 3'b000, 2'd0, 1'b0);
      rst_n = 1'b1;
      tick(2);
      chk_all("post_reset", 3'b000, 2'd0, 1'b0);

      // First light: default bulb exactly 7 cycles after the raw edge
      main_sw = 1'b1;
      sel_sw  = 2'b00;
      for (int i = 1; i <= 7; i++) begin
         tick(1);
         if (i < 7) chk("first_light.dark", int'(bulb), 0);
         chk("first_light.busy", int'(busy), 0);
      end
      chk("first_light.bulb", int'(bulb), 4);
      chk("first_light.idx", int'(active_idx), 2);

      // Bulb change 2 -> 0 with two dead cycles
      sel_sw = 2'b01;
      for (int i = 1; i <= 9; i++) begin
         tick(1);
         if (i <= 6)      chk_all("change.before", 3'b100, 2'd2, 1'b0);
         else if (i <= 8) chk_all("change.dead", 3'b000, 2'd2, 1'b1);
         else             chk_all("change.after", 3'b001, 2'd0, 1'b0);
      end

      // 3-cycle glitch on both select bits is filtered
      sel_sw = 2'b10;
      tick(3);
      sel_sw = 2'b01;
      for (int i = 1; i <= 12; i++) begin
         tick(1);
         chk_all("glitch", 3'b001, 2'd0, 1'b0);
      end

      // Two bits set selects the default bulb after dead time
      sel_sw = 2'b11;
      for (int i = 1; i <= 9; i++) begin
         tick(1);
         if (i <= 6)      chk_all("multi.before", 3'b001, 2'd0, 1'b0);
         else if (i <= 8) chk_all("multi.dead", 3'b000, 2'd0, 1'b1);
         else             chk_all("multi.after", 3'b100, 2'd2, 1'b0);
      end

      // Main switch drops during DEAD: straight to IDLE
      sel_sw = 2'b01;
      tick(1);
      main_sw = 1'b0;
      for (int i = 2; i <= 18; i++) begin
         tick(1);
         if (i <= 6)       chk_all("abort.before", 3'b100, 2'd2, 1'b0);
         else if (i == 7)  chk_all("abort.dead", 3'b000, 2'd2, 1'b1);
         else              chk_all("abort.idle", 3'b000, 2'd2, 1'b0);
      end

      // Asynchronous reset mid-ON, then clean restart without dead time
      main_sw = 1'b1;
      tick(12);
      chk_all("pre_reset_on", 3'b001, 2'd0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_reset", 3'b000, 2'd0, 1'b0);
      tick(2);
      rst_n = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick(1);
         if (i < 7) chk("restart.dark", int'(bulb), 0);
         chk("restart.busy", int'(busy), 0);
      end
      chk("restart.bulb", int'(bulb), 1);
      chk("restart.idx", int'(active_idx), 0);

      // Blink mode on bulb 1
      sel_sw = 2'b10;
      tick(12);
      chk_all("blink.setup", 3'b010, 2'd1, 1'b0);
      blink_en = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick(1);
         if (i <= 13 || (i >= 22 && i <= 29)) chk("blink.on", int'(bulb), 2);
         else                                 chk("blink.off", int'(bulb), 0);
         chk("blink.busy", int'(busy), 0);
      end
      // Dropping blink at the start of an off phase forces the bulb on early
      blink_en = 1'b0;
      for (int i = 1; i <= 27; i++) begin
         tick(1);
         if (i <= 6) chk("unblink.off", int'(bulb), 0);
         else        chk("unblink.steady", int'(bulb), 2);
      end

      // Target changes during DEAD: latest target wins, no extra dead period
      sel_sw = 2'b01;
      tick(12);
      chk_all("latest.setup", 3'b001, 2'd0, 1'b0);
      sel_sw = 2'b11;
      tick(1);
      sel_sw = 2'b10;
      for (int i = 2; i <= 14; i++) begin
         tick(1);
         if (i <= 6)      chk_all("latest.before", 3'b001, 2'd0, 1'b0);
         else if (i <= 8) chk_all("latest.dead", 3'b000, 2'd0, 1'b1);
         else             chk_all("latest.after", 3'b010, 2'd1, 1'b0);
      end

      // Table of steady-state vectors from a fresh reset
      main_sw = 1'b0;
      sel_sw  = 2'b00;
      rst_n   = 1'b0;
      tick(2);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         main_sw = vt[k].m;
         sel_sw  = vt[k].s;
         tick(vt[k].hold);
         chk_all($sformatf("vec%0d", k), vt[k].e_bulb, vt[k].e_idx, vt[k].e_busy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
